fma_issue_sched: RTL and testbench

Round-robin issue scheduler that shares one fixed-latency, non-stallable 32-bit FMA datapath (result = a*b + c) among NREQ requesters. It arbitrates valid/ready requests and registers the winning operands onto the datapath inputs. It tracks each in-flight operation with a requester tag and captures results into a response FIFO. Credit-based issue control guarantees the FIFO never overflows, even though the datapath itself cannot be stalled.

---
 rtl/fma_issue_sched_if.sv | 32 +++
 rtl/fma_issue_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_fma_issue_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fma_issue_sched_if.sv
// Handshake and datapath bundle for fma_issue_sched: requester side, FMA datapath side, response side.
// The slave modport is the scheduler; the master modport is its environment (requesters, datapath, consumer).
interface fma_issue_sched_if #(
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [NREQ*32-1:0] req_c;
   logic [31:0]        fma_a;
   logic [31:0]        fma_b;
   logic [31:0]        fma_c;
   logic [31:0]        fma_result;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_data;
   logic [IDW-1:0]     rsp_id;
   logic               busy;

   modport slave (
      input  req_valid, req_a, req_b, req_c, fma_result, rsp_ready,
      output req_ready, fma_a, fma_b, fma_c, rsp_valid, rsp_data, rsp_id, busy
   );

   modport master (
      output req_valid, req_a, req_b, req_c, fma_result, rsp_ready,
      input  req_ready, fma_a, fma_b, fma_c, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/fma_issue_sched.sv
// Credit-controlled issue scheduler sharing one fixed-latency, non-stallable FMA datapath among NREQ requesters.
// Define FMA_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).

module fma_issue_sched_chk #(
   parameter int FIFO_DEPTH = 4,
   parameter int OCW        = 3
) (
   input logic           clk,
   input logic           rst_n,
   input logic           cap_i,
   input logic           full_i,
   input logic [OCW-1:0] occ_i
);
   // Credits must make a capture into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(cap_i && full_i));

   // Occupancy never exceeds the credit limit.
   a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n) occ_i <= OCW'(FIFO_DEPTH));
endmodule

module fma_issue_sched #(
   parameter int NREQ       = 4,
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 4
) (
   input logic              clk,
   input logic              rst_n,
   fma_issue_sched_if.slave bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int OCW = $clog2(FIFO_DEPTH + 1);
   localparam int PTW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [OCW-1:0] occ_q, occ_d;
   logic [OCW-1:0] fcnt_q, fcnt_d;
   logic [PTW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]    mem_data_q [FIFO_DEPTH];
   logic [IDW-1:0] mem_id_q   [FIFO_DEPTH];
   logic [LAT:0]   tag_vld_q, tag_vld_d;
   logic [IDW-1:0] tag_id_q   [LAT+1];
   logic [IDW-1:0] tag_id_d   [LAT+1];
   logic [31:0]    fma_a_q, fma_b_q, fma_c_q;
   logic [31:0]    fma_a_d, fma_b_d, fma_c_d;

   logic [NREQ-1:0] grant_s;
   logic [IDW-1:0]  win_s;
   logic [IDW-1:0]  idx_s;
   logic            found_s;
   logic            issue_en_s;
   logic            issue_s;
   logic            pop_s;
   logic            cap_s;
   logic            fifo_full_s;
   logic            fifo_nempty_s;

`ifdef FMA_SCHED_RR_EN
   logic [IDW-1:0]  rr_last_q, rr_last_d;
`endif

   function automatic logic [PTW-1:0] ptr_inc(input logic [PTW-1:0] p);
      if (p == PTW'(FIFO_DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTW'(1);
      end
   endfunction

   // Winner search: first valid requester, starting after the last grant when round-robin is enabled.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      idx_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef FMA_SCHED_RR_EN
         idx_s = IDW'((int'(rr_last_q) + 1 + k) % NREQ);
`else
         idx_s = IDW'(k);
`endif
         if (!found_s && bus.req_valid[idx_s]) begin
            found_s = 1'b1;
            win_s   = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // No same-cycle pop bypass: only the registered occupancy gates issue.
   assign issue_en_s    = rst_n && (occ_q < OCW'(FIFO_DEPTH));
   assign fifo_nempty_s = (fcnt_q != '0);
   assign fifo_full_s   = (fcnt_q == OCW'(FIFO_DEPTH));
   assign pop_s         = fifo_nempty_s && bus.rsp_ready;
   assign cap_s         = tag_vld_q[LAT];
   assign issue_s       = issue_en_s && found_s;

   // One-hot grant towards the winning requester.
   always_comb begin
      grant_s = '0;
      if (issue_s) begin
         grant_s[win_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   // Next-state: occupancy, FIFO count/pointers, operand registers, tag pipeline.
   always_comb begin
      occ_d    = occ_q;
      fcnt_d   = fcnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fma_a_d  = fma_a_q;
      fma_b_d  = fma_b_q;
      fma_c_d  = fma_c_q;

      case ({issue_s, pop_s})
         2'b10:   occ_d = occ_q + OCW'(1);
         2'b01:   occ_d = occ_q - OCW'(1);
         default: occ_d = occ_q;
      endcase

      case ({cap_s, pop_s})
         2'b10:   fcnt_d = fcnt_q + OCW'(1);
         2'b01:   fcnt_d = fcnt_q - OCW'(1);
         default: fcnt_d = fcnt_q;
      endcase

      if (cap_s) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (issue_s) begin
         fma_a_d = bus.req_a[32*win_s +: 32];
         fma_b_d = bus.req_b[32*win_s +: 32];
         fma_c_d = bus.req_c[32*win_s +: 32];
      end else begin
         fma_a_d = fma_a_q;
         fma_b_d = fma_b_q;
         fma_c_d = fma_c_q;
      end

      tag_vld_d[0] = issue_s;
      tag_id_d[0]  = win_s;
      for (int k = 1; k <= LAT; k++) begin
         tag_vld_d[k] = tag_vld_q[k-1];
         tag_id_d[k]  = tag_id_q[k-1];
      end
   end

`ifdef FMA_SCHED_RR_EN
   // The round-robin pointer only moves on an actual issue.
   always_comb begin
      rr_last_d = rr_last_q;
      if (issue_s) begin
         rr_last_d = win_s;
      end else begin
         rr_last_d = rr_last_q;
      end
   end
`endif

   // State registers; reset also drops any datapath results still in flight by clearing the tags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q     <= '0;
         fcnt_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         tag_vld_q <= '0;
         fma_a_q   <= 32'd0;
         fma_b_q   <= 32'd0;
         fma_c_q   <= 32'd0;
         for (int k = 0; k <= LAT; k++) begin
            tag_id_q[k] <= '0;
         end
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_data_q[k] <= 32'd0;
            mem_id_q[k]   <= '0;
         end
`ifdef FMA_SCHED_RR_EN
         rr_last_q <= IDW'(NREQ - 1);
`endif
      end else begin
         occ_q     <= occ_d;
         fcnt_q    <= fcnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         tag_vld_q <= tag_vld_d;
         fma_a_q   <= fma_a_d;
         fma_b_q   <= fma_b_d;
         fma_c_q   <= fma_c_d;
         for (int k = 0; k <= LAT; k++) begin
            tag_id_q[k] <= tag_id_d[k];
         end
         if (cap_s) begin
            mem_data_q[wr_ptr_q] <= bus.fma_result;
            mem_id_q[wr_ptr_q]   <= tag_id_q[LAT];
         end
`ifdef FMA_SCHED_RR_EN
         rr_last_q <= rr_last_d;
`endif
      end
   end

   assign bus.req_ready = grant_s;
   assign bus.fma_a     = fma_a_q;
   assign bus.fma_b     = fma_b_q;
   assign bus.fma_c     = fma_c_q;
   assign bus.rsp_valid = fifo_nempty_s;
   assign bus.rsp_data  = fifo_nempty_s ? mem_data_q[rd_ptr_q] : 32'd0;
   assign bus.rsp_id    = fifo_nempty_s ? mem_id_q[rd_ptr_q] : '0;
   assign bus.busy      = (occ_q != '0);

   fma_issue_sched_chk #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .OCW        (OCW)
   ) u_chk (
      .clk    (clk),
      .rst_n  (rst_n),
      .cap_i  (cap_s),
      .full_i (fifo_full_s),
      .occ_i  (occ_q)
   );
endmodule

// File: tb/tb_fma_issue_sched.sv
// Scoreboard bench for fma_issue_sched: a reference model predicts grants and queues expected responses,
// a separate monitor pops and compares them. The external FMA datapath is modelled as a LAT-stage pipeline.
module tb_fma_issue_sched;
   localparam int NREQ = 4;
   localparam int LAT  = 3;
   localparam int FD   = 4;
   localparam int IDW  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fma_issue_sched_if #(.NREQ(NREQ)) bus ();

   fma_issue_sched #(
      .NREQ       (NREQ),
      .LAT        (LAT),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    data;
      int             rdy;
   } exp_t;

   exp_t sb_q [$];
   int   cyc      = 0;
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   mdl_last = NREQ - 1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic real sp2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0) d = {x[31], 63'd0};
      else d = {x[31], 11'({3'd0, x[30:23]} + 11'd896), x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      e = d[62:52];
      if (e <= 11'd896) return {d[63], 31'd0};
      else if (e >= 11'd1151) return {d[63], 8'hFF, 23'd0};
      else return {d[63], 8'(e - 11'd896), d[51:29]};
   endfunction

   function automatic logic [31:0] fma_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return r2sp(sp2r(a) * sp2r(b) + sp2r(c));
   endfunction

   function automatic logic [31:0] rnd_sp();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
   endtask

   // External datapath: result appears LAT cycles after operands are presented.
   logic [31:0] dp_q [LAT];
   always @(posedge clk) begin
      dp_q[0] <= fma_fn(bus.fma_a, bus.fma_b, bus.fma_c);
      for (int k = 1; k < LAT; k++) dp_q[k] <= dp_q[k-1];
   end
   assign bus.fma_result = dp_q[LAT-1];

   // One stimulus cycle: drive inputs, predict the grant, queue the expected response of any issue.
   task automatic step(input logic [NREQ-1:0] v, input logic rr, input logic rst_lo, input logic directed);
      logic [NREQ-1:0] exp_g;
      int w;
      exp_t e;
      @(negedge clk);
      rst_n         = ~rst_lo;
      bus.req_valid = v;
      bus.rsp_ready = rr;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[32*i +: 32] = rnd_sp();
         bus.req_b[32*i +: 32] = rnd_sp();
         bus.req_c[32*i +: 32] = rnd_sp();
      end
      if (directed) begin
         bus.req_a[31:0] = 32'h3F800000;
         bus.req_b[31:0] = 32'h40000000;
         bus.req_c[31:0] = 32'h40400000;
      end
      #1;
      if (rst_lo) begin
         chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
         sb_q.delete();
         mdl_last = NREQ - 1;
      end else begin
         chk("busy", 64'(bus.busy), 64'(sb_q.size() != 0));
         exp_g = '0;
         w = -1;
         if (sb_q.size() < FD) begin
            for (int k = 0; k < NREQ; k++) begin
`ifdef FMA_SCHED_RR_EN
               int j = (mdl_last + 1 + k) % NREQ;
`else
               int j = k;
`endif
               if (w < 0 && v[j]) w = j;
            end
         end
         if (w >= 0) exp_g[w] = 1'b1;
         chk("req_ready", 64'(bus.req_ready), 64'(exp_g));
         if (w >= 0) begin
            e.id   = IDW'(w);
            e.data = directed ? 32'h40A00000
                              : fma_fn(bus.req_a[32*w +: 32], bus.req_b[32*w +: 32], bus.req_c[32*w +: 32]);
            e.rdy  = cyc + LAT + 2;
            sb_q.push_back(e);
            mdl_last = w;
         end
      end
   endtask

   // Monitor: checks response outputs against the scoreboard head and retires it on a pop.
   initial begin
      logic ev;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            ev = (sb_q.size() > 0) && (cyc >= sb_q[0].rdy);
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
            if (ev) begin
               chk("rsp_data", 64'(bus.rsp_data), 64'(sb_q[0].data));
               chk("rsp_id", 64'(bus.rsp_id), 64'(sb_q[0].id));
               if (bus.rsp_ready) void'(sb_q.pop_front());
            end else begin
               chk("rsp_empty_zero", 64'({bus.rsp_id, bus.rsp_data}), 64'd0);
            end
         end
      end
   end

   initial begin
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_c     = '0;

      repeat (2) step(4'b1111, 1'b1, 1'b1, 1'b0);

      // Single request with known operands: 1*2+3.
      step(4'b0001, 1'b1, 1'b0, 1'b1);
      repeat (8) step(4'b0000, 1'b1, 1'b0, 1'b0);

      // Everybody requesting continuously.
      repeat (30) step(4'b1111, 1'b1, 1'b0, 1'b0);
      repeat (8) step(4'b0000, 1'b1, 1'b0, 1'b0);

      // Credit stall on requester 2, then a single-cycle pop.
      repeat (10) step(4'b0100, 1'b0, 1'b0, 1'b0);
      step(4'b0100, 1'b1, 1'b0, 1'b0);
      repeat (5) step(4'b0100, 1'b0, 1'b0, 1'b0);
      repeat (10) step(4'b0000, 1'b1, 1'b0, 1'b0);

      // Reset with one response in the FIFO and two operations in flight.
      step(4'b0001, 1'b0, 1'b0, 1'b0);
      repeat (4) step(4'b0000, 1'b0, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("fma_a_rst", 64'(bus.fma_a), 64'd0);
      chk("fma_b_rst", 64'(bus.fma_b), 64'd0);
      chk("fma_c_rst", 64'(bus.fma_c), 64'd0);
      repeat (10) step(4'b0000, 1'b1, 1'b0, 1'b0);
      repeat (6) step(4'b1111, 1'b1, 1'b0, 1'b0);

      // Randomized traffic with random back-pressure.
      for (int n = 0; n < 400; n++) begin
         step(NREQ'($urandom), ($urandom_range(0, 9) < 7), 1'b0, 1'b0);
      end

      repeat (20) step(4'b0000, 1'b1, 1'b0, 1'b0);
      chk("drained", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
